// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, opcodes and instruction-register field positions
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int IR_W      = 8;
    localparam int IR_OP_HI  = 7;
    localparam int IR_OP_LO  = 4;
    localparam int IR_RD_HI  = 3;
    localparam int IR_RD_LO  = 2;
    localparam int IR_RS2_HI = 1;
    localparam int IR_RS2_LO = 0;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with reset value, parallel load and wrapping increment
module pc_counter #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_val,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Load beats increment; the increment wraps naturally at the register width
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - FETCH/ISSUE/HALT instruction fetch FSM with IR; FETCH_JUMP_EN adds jmp_en/jmp_addr
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
`ifdef FETCH_JUMP_EN
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            imem_ack,
    input  logic            pc_en,
    output logic [3:0]      op,
    output logic [1:0]      rd,
    output logic [1:0]      rs2,
    output logic            instr_valid,
    output logic            halted
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IR_W-1:0] r_ir;
    logic            w_ir_load;
    logic            w_pc_step;
    logic            w_pc_load;
    logic            w_pc_inc;
    logic [PC_W-1:0] w_pc_target;
    logic [PC_W-1:0] w_pc;

    // State register; reset also abandons any outstanding memory request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: ack only counts in FETCH, pc_en only counts in ISSUE, HALT is sticky
    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_pc_step   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = (imem_rdata[IR_OP_HI:IR_OP_LO] == OP_HALT) ? ST_HALT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pc_en) begin
                    w_pc_step   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Instruction register captures the returned word on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= imem_rdata;
        end
    end

`ifdef FETCH_JUMP_EN
    assign w_pc_load   = w_pc_step & jmp_en;
    assign w_pc_target = jmp_addr;
`else
    assign w_pc_load   = 1'b0;
    assign w_pc_target = RESET_PC;
`endif
    assign w_pc_inc = w_pc_step & ~w_pc_load;

    pc_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_target),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = w_pc;
    assign instr_valid = (r_state == ST_ISSUE);
    assign halted      = (r_state == ST_HALT);
    assign op          = instr_valid ? r_ir[IR_OP_HI:IR_OP_LO] : OP_NOP;
    assign rd          = r_ir[IR_RD_HI:IR_RD_LO];
    assign rs2         = r_ir[IR_RS2_HI:IR_RS2_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    localparam int         PC_W   = 8;
    localparam logic [7:0] RST_PC = 8'hFC;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_ack;
    logic       pc_en;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs2;
    logic       instr_valid;
    logic       halted;
`ifdef FETCH_JUMP_EN
    logic       jmp_en;
    logic [7:0] jmp_addr;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_pc;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FETCH_JUMP_EN
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
`endif
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pc_en       (pc_en),
        .op          (op),
        .rd          (rd),
        .rs2         (rs2),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        pc_en = 1'b0;
        imem_rdata = 8'h00;
        tick();
        checks++;
        if ({imem_req, imem_addr, instr_valid, halted, op, rd, rs2} !== {1'b1, RST_PC, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL reset_state got req=%b addr=%h iv=%b halt=%b op=%h rd=%b rs2=%b, want req=1 addr=%h iv=0 halt=0 op=0 rd=00 rs2=00",
                     imem_req, imem_addr, instr_valid, halted, op, rd, rs2, RST_PC);
        end
        rst = 1'b0;
        exp_pc = RST_PC;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL req_after_release got req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    // Waits 'delay' cycles (with stray pc_en pulses) then acks with 'data'
    task automatic do_fetch(input logic [7:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin
                errors++;
                $display("FAIL fetch_wait%0d got req=%b addr=%h, want req=1 addr=%h", i, imem_req, imem_addr, exp_pc);
            end
            pc_en = 1'b1;
            tick();
            pc_en = 1'b0;
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin
            errors++;
            $display("FAIL fetch_ack_cycle got req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_pc);
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        if (data[7:4] != 4'hF) sb_q.push_back(data);
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic issue_instr(input logic jump, input logic [7:0] target);
        logic [7:0] exp_w;
        int waited;
        waited = 0;
        while (instr_valid !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        checks++;
        if (waited != 0) begin
            errors++;
            $display("FAIL issue_latency got %0d extra cycles, want 0", waited);
        end
        exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if ({op, rd, rs2} !== exp_w) begin
            errors++;
            $display("FAIL issue_fields got op=%h rd=%b rs2=%b, want %h", op, rd, rs2, exp_w);
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL issue_req got %b, want 0", imem_req);
        end
        imem_ack = 1'b1;
        imem_rdata = ~exp_w;
        tick();
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, op, rd, rs2} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL issue_hold got iv=%b op=%h rd=%b rs2=%b, want iv=1 %h", instr_valid, op, rd, rs2, exp_w);
        end
        pc_en = 1'b1;
`ifdef FETCH_JUMP_EN
        jmp_en = jump;
        jmp_addr = target;
`endif
        tick();
        pc_en = 1'b0;
`ifdef FETCH_JUMP_EN
        jmp_en = 1'b0;
`endif
        exp_pc = jump ? target : exp_pc + 8'd1;
    endtask

    // FC..FF then wrap to 00, with a 3-cycle ack delay mixed in
    task automatic test_sequence_wrap();
        do_fetch(8'h1B, 0);
        issue_instr(1'b0, 8'h00);
        do_fetch(8'h27, 3);
        issue_instr(1'b0, 8'h00);
        do_fetch(8'h3C, 1);
        issue_instr(1'b0, 8'h00);
        do_fetch(8'h81, 0);
        issue_instr(1'b0, 8'h00);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL pc_wrap got req=%b addr=%h, want req=1 addr=00", imem_req, imem_addr);
        end
    endtask

    task automatic test_halt();
        do_fetch(8'hF0, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({halted, instr_valid, op, imem_req, imem_addr} !== {1'b1, 1'b0, 4'h0, 1'b0, exp_pc}) begin
                errors++;
                $display("FAIL halt_hold%0d got halt=%b iv=%b op=%h req=%b addr=%h, want halt=1 iv=0 op=0 req=0 addr=%h",
                         i, halted, instr_valid, op, imem_req, imem_addr, exp_pc);
            end
            pc_en = i[0];
            imem_ack = ~i[0];
            imem_rdata = 8'h1B;
            tick();
        end
        pc_en = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        test_reset();
        tick();
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 8'h5A;
        tick();
        rst = 1'b0;
        imem_ack = 1'b0;
        exp_pc = RST_PC;
        checks++;
        if ({instr_valid, rd, rs2, imem_addr, imem_req} !== {1'b0, 2'b00, 2'b00, RST_PC, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_req got iv=%b rd=%b rs2=%b addr=%h req=%b, want iv=0 rd=00 rs2=00 addr=%h req=1",
                     instr_valid, rd, rs2, imem_addr, imem_req, RST_PC);
        end
        tick();
        checks++;
        if ({instr_valid, halted, imem_req} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ack_discard got iv=%b halt=%b req=%b, want iv=0 halt=0 req=1", instr_valid, halted, imem_req);
        end
    endtask

`ifdef FETCH_JUMP_EN
    task automatic test_jump();
        do_fetch(8'h26, 0);
        issue_instr(1'b1, 8'h40);
        checks++;
        if (imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL jump_target got addr=%h, want 40", imem_addr);
        end
        do_fetch(8'h45, 2);
        issue_instr(1'b0, 8'h00);
    endtask
`endif

    initial begin
`ifdef FETCH_JUMP_EN
        jmp_en = 1'b0;
        jmp_addr = 8'h00;
`endif
        test_reset();
        test_sequence_wrap();
        do_fetch(8'h52, 0);
        issue_instr(1'b0, 8'h00);
        test_halt();
        test_reset_mid_req();
`ifdef FETCH_JUMP_EN
        test_jump();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, default 8, program-counter and instruction-address width.
REQ-002 Parameter: RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: imem_req  output  1  instruction-memory read request.
REQ-006 Port: imem_addr  output  PC_W  read address, equal to current PC.
REQ-007 Port: imem_rdata  input  8  instruction word, valid when imem_ack=1.
REQ-008 Port: imem_ack  input  1  read-complete strobe, one cycle.
REQ-009 Port: pc_en  input  1  advance request from the downstream control unit.
REQ-010 Port: op  output  4  opcode field IR[7:4], forced 4'b0000 when instr_valid=0.
REQ-011 Port: rd  output  2  destination field IR[3:2].
REQ-012 Port: rs2  output  2  source field IR[1:0].
REQ-013 Port: instr_valid  output  1  IR holds an issued instruction.
REQ-014 Port: halted  output  1  HALT opcode reached.
REQ-015 Ports, FETCH_JUMP_EN only: jmp_en input 1 and jmp_addr input PC_W, jump request and target.

Function
REQ-016 The block SHALL implement three states: FETCH, ISSUE and HALT.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr=PC, both held stable until imem_ack=1.
REQ-018 On imem_ack in FETCH, the next edge SHALL load IR<=imem_rdata and go to ISSUE, unless imem_rdata[7:4]=4'b1111, in which case it SHALL go to HALT.
REQ-019 Minimum latency SHALL be ack cycle + 1 to instr_valid=1; an ack in the first request cycle is legal.
REQ-020 imem_ack outside FETCH SHALL be ignored, with no IR or state change.
REQ-021 In ISSUE, instr_valid SHALL be 1, imem_req SHALL be 0, and IR SHALL be held until pc_en=1.
REQ-022 On pc_en in ISSUE, PC<=PC+1 modulo 2^PC_W (all-ones wraps to 0), and state SHALL return to FETCH.
REQ-023 pc_en in FETCH or HALT SHALL be ignored.
REQ-024 In HALT: halted=1, instr_valid=0, imem_req=0, PC frozen; only reset exits.
REQ-025 op SHALL read 4'b0000 (no-op to the control unit) whenever instr_valid=0.

Reset
REQ-026 With rst=1 at an edge: state=FETCH, PC=RESET_PC, IR=8'h00, instr_valid=0, halted=0.
REQ-027 imem_req=1 SHALL be asserted in the first cycle after reset release.
REQ-028 Reset mid-request SHALL drop the outstanding request; an ack arriving in the reset cycle SHALL be discarded.

Configuration
REQ-029 Macro FETCH_JUMP_EN defined: on pc_en&jmp_en in ISSUE, PC<=jmp_addr; jump SHALL have priority over increment.
REQ-030 Macro FETCH_JUMP_EN undefined: the jmp_en and jmp_addr ports SHALL be absent, and PC SHALL only increment or reset.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, OP_NOP=4'b0000, OP_HALT=4'b1111, and IR field bit positions.
REQ-032 The PC register SHALL be one sub-module, pc_counter, providing load, increment, wrap and reset value.
REQ-033 The FSM and IR SHALL live in fetch_unit; outputs SHALL be registered or decoded from registers only.

Verification
REQ-034 Reset, ack in first req cycle with rdata=8'h1B -> next cycle instr_valid=1, op=4'h1, rd=2'b10, rs2=2'b11.
REQ-035 Ack delayed 3 cycles -> imem_req high and imem_addr stable for 4 cycles; pc_en then yields imem_addr=PC+1.
REQ-036 PC=8'hFF with pc_en -> next imem_addr=8'h00.
REQ-037 rdata=8'hF0 -> halted=1, op=0, imem_req=0 indefinitely; pc_en and ack pulses cause no change.
REQ-038 Reset asserted while waiting for ack, ack in same cycle -> IR stays 8'h00, PC=RESET_PC, instr_valid=0.
REQ-039 With FETCH_JUMP_EN, pc_en+jmp_en with jmp_addr=8'h40 in ISSUE -> next imem_addr=8'h40.
